// File: rtl/ring_fifo.sv
// Circular-buffer FIFO with first-word-fall-through output, full/empty/count status,
// optional overwrite-oldest mode and sticky overflow/underflow flags.
module ring_fifo #(
    parameter int WIDTH        = 64,
    parameter int DEPTH        = 8,
    parameter int AFULL_THRESH = DEPTH - 1,
    parameter bit OVERWRITE    = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    input  logic                       flush,
    input  logic                       clear_err,
    output logic                       empty,
    output logic                       full,
    output logic                       almost_full,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic             overflow_q;
    logic             underflow_q;

    logic is_empty;
    logic is_full;
    logic wr_en;
    logic rd_adv;
    logic set_ovf;
    logic set_udf;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CW'(DEPTH));

    always_comb begin
        wr_en   = 1'b0;
        rd_adv  = 1'b0;
        set_ovf = 1'b0;
        set_udf = 1'b0;
        if (!flush) begin
            if (push) begin
                if (!is_full || pop) begin
                    wr_en = 1'b1;
                end else if (OVERWRITE) begin
                    // Full with no pop: write over the oldest entry and step past it.
                    wr_en   = 1'b1;
                    rd_adv  = 1'b1;
                    set_ovf = 1'b1;
                end else begin
                    set_ovf = 1'b1;
                end
            end
            if (pop) begin
                if (is_empty) begin
                    set_udf = 1'b1;
                end else begin
                    rd_adv = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                count_q <= '0;
            end else begin
                if (wr_en) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (rd_adv) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                if (wr_en && !rd_adv) begin
                    count_q <= count_q + 1'b1;
                end else if (rd_adv && !wr_en) begin
                    count_q <= count_q - 1'b1;
                end
            end
            // A new error event wins over a coincident clear.
            overflow_q  <= set_ovf | (overflow_q & ~clear_err);
            underflow_q <= set_udf | (underflow_q & ~clear_err);
        end
    end

    assign dout        = is_empty ? '0 : mem[rd_ptr];
    assign empty       = is_empty;
    assign full        = is_full;
    assign almost_full = (count_q >= CW'(AFULL_THRESH));
    assign count       = count_q;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;

endmodule

// File: tb/tb_ring_fifo.sv
// Bench for ring_fifo: one instance per overwrite mode driven in lockstep, each checked
// against a queue-based reference model after every clock edge.
module tb_ring_fifo;

    localparam int WIDTH = 64;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             push;
    logic [WIDTH-1:0] din;
    logic             pop;
    logic             flush;
    logic             clear_err;

    logic [WIDTH-1:0] dout_a        [2];
    logic             empty_a       [2];
    logic             full_a        [2];
    logic             almost_full_a [2];
    logic [CW-1:0]    count_a       [2];
    logic             overflow_a    [2];
    logic             underflow_a   [2];

    logic [WIDTH-1:0] mq [2][$];
    bit               mo [2];
    bit               mu [2];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ring_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_THRESH(DEPTH - 1), .OVERWRITE(1'b0)) u_drop (
        .clk(clk), .rst_n(rst_n), .push(push), .din(din), .pop(pop), .dout(dout_a[0]),
        .flush(flush), .clear_err(clear_err), .empty(empty_a[0]), .full(full_a[0]),
        .almost_full(almost_full_a[0]), .count(count_a[0]), .overflow(overflow_a[0]),
        .underflow(underflow_a[0])
    );

    ring_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_THRESH(DEPTH - 1), .OVERWRITE(1'b1)) u_ovw (
        .clk(clk), .rst_n(rst_n), .push(push), .din(din), .pop(pop), .dout(dout_a[1]),
        .flush(flush), .clear_err(clear_err), .empty(empty_a[1]), .full(full_a[1]),
        .almost_full(almost_full_a[1]), .count(count_a[1]), .overflow(overflow_a[1]),
        .underflow(underflow_a[1])
    );

    task automatic check(input int m, input string tag, input logic [WIDTH-1:0] obs,
                         input logic [WIDTH-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL inst%0d %s observed=%0h expected=%0h", m, tag, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int m = 0; m < 2; m++) begin
            int n;
            n = mq[m].size();
            check(m, "count", WIDTH'(count_a[m]), WIDTH'(n));
            check(m, "empty", WIDTH'(empty_a[m]), WIDTH'(n == 0));
            check(m, "full", WIDTH'(full_a[m]), WIDTH'(n == DEPTH));
            check(m, "almost_full", WIDTH'(almost_full_a[m]), WIDTH'(n >= DEPTH - 1));
            check(m, "dout", dout_a[m], (n > 0) ? mq[m][0] : '0);
            check(m, "overflow", WIDTH'(overflow_a[m]), WIDTH'(mo[m]));
            check(m, "underflow", WIDTH'(underflow_a[m]), WIDTH'(mu[m]));
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            mq[m].delete();
            mo[m] = 1'b0;
            mu[m] = 1'b0;
        end
    endtask

    task automatic model_step(input bit p, input logic [WIDTH-1:0] d, input bit po,
                              input bit fl, input bit ce);
        for (int m = 0; m < 2; m++) begin
            bit so, su, was_empty, was_full;
            so = 1'b0;
            su = 1'b0;
            if (fl) begin
                mq[m].delete();
            end else begin
                was_empty = (mq[m].size() == 0);
                was_full  = (mq[m].size() == DEPTH);
                if (po) begin
                    if (was_empty) su = 1'b1;
                    else void'(mq[m].pop_front());
                end
                if (p) begin
                    if (!was_full || po) begin
                        mq[m].push_back(d);
                    end else if (m == 1) begin
                        void'(mq[m].pop_front());
                        mq[m].push_back(d);
                        so = 1'b1;
                    end else begin
                        so = 1'b1;
                    end
                end
            end
            mo[m] = so | (mo[m] & ~ce);
            mu[m] = su | (mu[m] & ~ce);
        end
    endtask

    task automatic step(input bit p, input logic [WIDTH-1:0] d, input bit po,
                        input bit fl = 1'b0, input bit ce = 1'b0);
        push      = p;
        din       = d;
        pop       = po;
        flush     = fl;
        clear_err = ce;
        @(posedge clk);
        #1;
        model_step(p, d, po, fl, ce);
        push      = 1'b0;
        pop       = 1'b0;
        flush     = 1'b0;
        clear_err = 1'b0;
        din       = '0;
        check_all();
    endtask

    initial begin
        rst_n     = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        flush     = 1'b0;
        clear_err = 1'b0;
        din       = '0;
        model_reset();
        #2;
        check_all();
        #4;
        rst_n = 1'b1;

        // Fill 1..8 then drain in order.
        for (int i = 1; i <= DEPTH; i++) step(1'b1, WIDTH'(i), 1'b0);
        for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1);

        // Push while full: dropped in one mode, oldest overwritten in the other.
        for (int i = 1; i <= DEPTH; i++) step(1'b1, WIDTH'(i), 1'b0);
        step(1'b1, 64'h9, 1'b0);
        for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);

        // Push+pop while full, then push+pop while empty.
        for (int i = 1; i <= DEPTH; i++) step(1'b1, WIDTH'(i), 1'b0);
        step(1'b1, 64'h55, 1'b1);
        for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1);
        step(1'b1, 64'hA, 1'b1);

        // clear_err with a coincident underflow keeps it; clear alone drops it.
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);

        // Alternating push/pop across pointer wrap.
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) step(1'b1, WIDTH'(64'h100 + i), 1'b0);
            else            step(1'b0, '0, 1'b1);
            tests++;
            assert (count_a[0] <= 1) else begin
                fails++;
                $error("FAIL wrap_count observed=%0d required<=1", count_a[0]);
            end
        end

        // Flush at count 5 with a concurrent push.
        for (int i = 1; i <= 5; i++) step(1'b1, WIDTH'(64'h200 + i), 1'b0);
        step(1'b1, 64'hDEAD, 1'b0, 1'b1, 1'b0);
        step(1'b0, '0, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 24) == 0), ($urandom_range(0, 9) == 0));
        end

        // Asynchronous reset in the middle of traffic.
        for (int i = 0; i < 5; i++) step(1'b1, {$urandom, $urandom}, 1'b0);
        step(1'b1, 64'h77, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1);
        push = 1'b1;
        din  = 64'h1234;
        rst_n = 1'b0;
        #2;
        model_reset();
        check_all();
        push  = 1'b0;
        din   = '0;
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step(1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ring_fifo.md
# ring_fifo

Parametrised circular-buffer FIFO that replaces the fixed shift-register `fifo` behind the MMIO user-register path in the AFU. Host MMIO writes push words and MMIO reads pop them. Unlike its predecessor, it has:
- configurable width and depth;
- real push/pop handshakes with full/empty/count status;
- an optional overwrite-oldest mode;
- sticky overflow/underflow error flags that the AFU exposes through its CSR space.

## Interface
Parameters:
- `WIDTH`, 64, data word width in bits (≥1).
- `DEPTH`, 8, number of entries; power of two, ≥2.
- `AFULL_THRESH`, DEPTH-1, `almost_full` asserts when count ≥ this value (1..DEPTH).
- `OVERWRITE`, 0, 0 = drop push when full; 1 = push when full discards oldest entry.

Ports:
- `clk`  in  1  single clock, all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `push`  in  1  write request; `din` sampled on same edge.
- `din`  in  WIDTH  write data.
- `pop`  in  1  read request; consumes the head entry.
- `dout`  out  WIDTH  head entry, first-word-fall-through; 0 when empty.
- `flush`  in  1  synchronous empty of FIFO contents.
- `clear_err`  in  1  synchronous clear of `overflow`/`underflow`.
- `empty`  out  1  count == 0.
- `full`  out  1  count == DEPTH.
- `almost_full`  out  1  count ≥ AFULL_THRESH.
- `count`  out  $clog2(DEPTH+1)  current occupancy.
- `overflow`  out  1  sticky: a pushed word was dropped, or the oldest word was overwritten.
- `underflow`  out  1  sticky: pop attempted while empty.

## Operation
State and storage:
- Storage `mem[DEPTH]` with `wr_ptr`/`rd_ptr` of $clog2(DEPTH) bits, wrapping naturally modulo DEPTH, plus a registered `count`.
- `mem` is not reset; pointers, count and flags are.

Per-edge priority: `flush` > push/pop.
- `flush`=1: `wr_ptr`, `rd_ptr` and `count` are set to 0, and push/pop that cycle are ignored. Flags are not changed by flush, and no flag is set that cycle.

Push/pop cases (no flush):
- Push, not full: `mem[wr_ptr]`←`din`, `wr_ptr`+1.
- Pop, not empty: `rd_ptr`+1.
- Pop while empty: ignored, `underflow`←1.
- Push while full, no pop, OVERWRITE=0: word dropped, `overflow`←1, state unchanged.
- Push while full, no pop, OVERWRITE=1: write at `wr_ptr`, both pointers +1, count stays DEPTH, `overflow`←1.
- Push+pop while full: both accepted, count unchanged, no flag set (either mode).
- Push+pop while empty: push accepted, pop ignored, count→1, `underflow`←1.
- Push+pop otherwise: both accepted, count unchanged.

Count and flags:
- `count` changes by +1, −1 or 0 per edge, never exceeding DEPTH.
- `clear_err` clears both flags. If a set condition coincides with `clear_err`, the set wins.

## Timing
- Reset (`rst_n`=0, asynchronous) values: `count`=0, `empty`=1, `full`=0, `almost_full`=0, `overflow`=0, `underflow`=0, `dout`=0. Pointers are 0.
- Release of `rst_n` is synchronised by the integrator; the block assumes deassertion is clean with respect to `clk`.
- `empty`, `full`, `almost_full` and `count` are derived from registered state and update on the same edge that performs the push/pop.
- Write-to-read latency: a word pushed at edge N into an empty FIFO appears on `dout` after edge N, with `empty`=0 in that same cycle.
- Pop effect: a pop at edge N presents the next entry (or 0 if now empty) after edge N.
- Throughput: one push and one pop per cycle sustained, with no bubbles at full or empty.
- Reset mid-operation: all contents are lost, and outputs take their reset values immediately (asynchronously).
- `dout` is combinational from `mem[rd_ptr]`, gated by `empty`. There is no extra register stage.

## Test plan
- **Reset:** assert `rst_n`=0 mid-traffic → `empty`=1, `count`=0, `dout`=0, flags 0 without waiting for a clock edge.
- **Fill/drain (DEPTH=8, WIDTH=64):** push 0x1..0x8 → `full`=1, `count`=8, `almost_full` from count 7; pop 8 times → `dout` reads 0x1..0x8 in order, then `empty`=1.
- **Overflow, OVERWRITE=0:**
  - Start full with 0x1..0x8, push 0x9 → `overflow`=1, contents unchanged, drain yields 0x1..0x8.
  - With OVERWRITE=1, the same stimulus → drain yields 0x2..0x9 and `overflow`=1.
- **Boundary simultaneity:**
  - Push+pop while full → `count` stays 8, no flag set.
  - Push 0xA+pop while empty → `count`=1, `dout`=0xA, `underflow`=1.
- **Wrap-around:** 20 cycles of alternating push/pop with incrementing data → strict in-order data across pointer wrap, and `count` never exceeds 1.
- **Flush/clear:**
  - Flush with count=5 plus a concurrent push → `count`=0, `empty`=1, pushed word absent.
  - `clear_err` coincident with a new underflow → `underflow` stays 1; next cycle `clear_err` alone → 0.
